// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory port arbiter: owner encodings,
// word width, grant-vector bit positions and the byte-to-word address helper.
package imem_pkg;

  localparam int WORD_W = 32;

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_LOAD  = 1'b1;

  localparam int GNT_F = 0;
  localparam int GNT_L = 1;

  // Byte address to word index; callers truncate to the memory depth, which is
  // what makes out-of-range addresses wrap.
  function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory port arbiter.
// slave = arbiter side, master = fetch/loader/memory environment side.
interface imem_port_arbiter_if
  import imem_pkg::*;
#(
  parameter int NUM_OF_BITS = 22
);

  logic                   f_req;
  logic [WORD_W-1:0]      f_addr;
  logic                   f_gnt;
  logic                   f_valid;
  logic [WORD_W-1:0]      f_data;
  logic                   f_misalign;

  logic                   l_req;
  logic [WORD_W-1:0]      l_addr;
  logic [WORD_W-1:0]      l_wdata;
  logic                   l_gnt;
  logic                   l_err;

  logic                   mem_en;
  logic                   mem_we;
  logic [NUM_OF_BITS-1:0] mem_addr;
  logic [WORD_W-1:0]      mem_wdata;
  logic [WORD_W-1:0]      mem_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_valid, f_data, f_misalign, l_gnt, l_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_valid, f_data, f_misalign, l_gnt, l_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_rr_pick.sv
// Fetch/loader priority pick with loader preference bounded by a starvation count.
// Produces a one-hot grant vector (GNT_F / GNT_L), all zero while in reset.
//
//   state   | meaning
//   S_FETCH | fetch won the last contested or uncontested grant
//   S_LOAD  | loader won last; starve_cnt counts its wins over a waiting fetch
module imem_rr_pick
  import imem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       f_req,
  input  logic       l_req,
  output logic [1:0] gnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [0:0] owner_q, owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [3:0] cnt_base;
  logic       starved;

  always_comb begin
    // The count only accumulates while the loader owns the port, so gating by
    // owner changes nothing functionally but keeps the two flops consistent.
    cnt_base = (owner_q == S_LOAD) ? starve_cnt_q : 4'd0;
    starved  = (cnt_base == LIMIT);

    gnt = 2'b00;
    if (!rst) begin
      if (f_req && (!l_req || starved)) begin
        gnt[GNT_F] = 1'b1;
      end else if (l_req) begin
        gnt[GNT_L] = 1'b1;
      end
    end

    owner_d = owner_q;
    if (gnt[GNT_L]) begin
      owner_d = S_LOAD;
    end else if (gnt[GNT_F]) begin
      owner_d = S_FETCH;
    end

    starve_cnt_d = 4'd0;
    if (gnt[GNT_L] && f_req) begin
      starve_cnt_d = starved ? LIMIT : cnt_base + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= S_FETCH;
      starve_cnt_q <= 4'd0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares a single-port synchronous IMEM between CPU fetch (read) and the program
// loader (write); one access per cycle, fetch data returned one cycle after grant.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int NUM_OF_BITS  = 22,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  imem_port_arbiter_if.slave bus
);

  logic [1:0]        gnt;
  logic              f_aligned;
  logic              l_aligned;

  logic              f_valid_q, f_valid_d;
  logic              f_misalign_q, f_misalign_d;
  logic              l_err_q, l_err_d;
  logic [WORD_W-1:0] f_data_hold_q, f_data_hold_d;
  logic [WORD_W-1:0] f_data_out;

  imem_rr_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk   (clk),
    .rst   (rst),
    .f_req (bus.f_req),
    .l_req (bus.l_req),
    .gnt   (gnt)
  );

  always_comb begin
    f_aligned = (bus.f_addr[1:0] == 2'b00);
    l_aligned = (bus.l_addr[1:0] == 2'b00);

    f_valid_d    = gnt[GNT_F];
    f_misalign_d = gnt[GNT_F] && !f_aligned;
    l_err_d      = gnt[GNT_L] && !l_aligned;

    // Memory read data is only live in the cycle after a read; otherwise replay
    // the last presented word so f_data holds steady.
    if (f_valid_q) begin
      f_data_out = f_misalign_q ? '0 : bus.mem_rdata;
    end else begin
      f_data_out = f_data_hold_q;
    end
    f_data_hold_d = f_data_out;
  end

  assign bus.f_gnt      = gnt[GNT_F];
  assign bus.l_gnt      = gnt[GNT_L];
  assign bus.mem_en     = (gnt[GNT_F] && f_aligned) || (gnt[GNT_L] && l_aligned);
  assign bus.mem_we     = gnt[GNT_L] && l_aligned;
  assign bus.mem_addr   = NUM_OF_BITS'(word_index(gnt[GNT_L] ? bus.l_addr : bus.f_addr));
  assign bus.mem_wdata  = bus.l_wdata;

  assign bus.f_valid    = f_valid_q;
  assign bus.f_misalign = f_misalign_q;
  assign bus.f_data     = f_data_out;
  assign bus.l_err      = l_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_valid_q     <= 1'b0;
      f_misalign_q  <= 1'b0;
      l_err_q       <= 1'b0;
      f_data_hold_q <= '0;
    end else begin
      f_valid_q     <= f_valid_d;
      f_misalign_q  <= f_misalign_d;
      l_err_q       <= l_err_d;
      f_data_hold_q <= f_data_hold_d;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: behavioural memory plus a rule-level reference
// model of arbitration, starvation and read/write effects.
module tb_imem_port_arbiter;

  localparam int NB    = 22;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.NUM_OF_BITS(NB)) bus ();

  imem_port_arbiter #(
    .NUM_OF_BITS  (NB),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(int idx);
    return 32'(idx) * 32'h0101_0101 + 32'hA5A5_0000;
  endfunction

  // environment memory, write-first single port
  logic [31:0] env_mem [int];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) env_mem[int'(bus.mem_addr)] = bus.mem_wdata;
      else bus.mem_rdata <= env_mem.exists(int'(bus.mem_addr)) ?
                            env_mem[int'(bus.mem_addr)] : init_word(int'(bus.mem_addr));
    end
  end

  // reference model
  logic [31:0] ref_mem [int];
  int          streak = 0;
  logic        e_fg = 0, e_lg = 0, e_en = 0, e_we = 0;
  logic [NB-1:0] e_addr = '0;
  logic        e_valid = 0, e_mis = 0, e_lerr = 0;
  logic [31:0] e_data = '0;

  function automatic int widx(logic [31:0] a);
    return int'((a / 32'd4) % (32'd1 << NB));
  endfunction

  function automatic logic [31:0] ref_read(int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  task automatic predict();
    if (rst) begin
      e_fg = 0; e_lg = 0; e_en = 0; e_we = 0;
    end else begin
      e_fg   = bus.f_req && (!bus.l_req || streak == LIMIT);
      e_lg   = bus.l_req && !e_fg;
      e_en   = (e_fg && bus.f_addr % 4 == 0) || (e_lg && bus.l_addr % 4 == 0);
      e_we   = e_lg && bus.l_addr % 4 == 0;
      e_addr = NB'(widx(e_lg ? bus.l_addr : bus.f_addr));
    end
  endtask

  task automatic commit();
    if (rst) begin
      streak = 0; e_valid = 0; e_mis = 0; e_lerr = 0; e_data = '0;
    end else begin
      e_valid = e_fg;
      e_mis   = e_fg && bus.f_addr % 4 != 0;
      e_lerr  = e_lg && bus.l_addr % 4 != 0;
      if (e_fg) e_data = e_mis ? 32'd0 : ref_read(widx(bus.f_addr));
      if (e_we) ref_mem[widx(bus.l_addr)] = bus.l_wdata;
      streak = (e_lg && bus.f_req) ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
    end
  endtask

  task automatic settle();
    predict();
    @(negedge clk);
  endtask

  task automatic end_cycle();
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr,
                       input logic [31:0] la, input logic [31:0] lw);
    bus.f_req = fr; bus.f_addr = fa; bus.l_req = lr; bus.l_addr = la; bus.l_wdata = lw;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom() & 32'hFF00_0000) | (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 32'h0, 1, 32'h40, 32'h1111_2222);
    settle();
    checks++;
    if ({bus.f_gnt, bus.l_gnt, bus.mem_en, bus.mem_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl got %b exp 0000", {bus.f_gnt, bus.l_gnt, bus.mem_en, bus.mem_we});
    end
    checks++;
    if ({bus.f_valid, bus.f_misalign, bus.l_err} !== 3'b000 || bus.f_data !== 32'd0) begin
      errors++; $display("FAIL reset_out got v/m/e %b data %h exp 000 / 0",
                         {bus.f_valid, bus.f_misalign, bus.l_err}, bus.f_data);
    end
    end_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    settle();
    checks++;
    if (bus.f_valid !== 1'b0 || bus.f_data !== 32'd0) begin
      errors++; $display("FAIL reset_release got v %b data %h exp 0 / 0", bus.f_valid, bus.f_data);
    end
    end_cycle();
  endtask

  task automatic test_fetch_seq();
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, 32'(4 * i), 0, 0, 0);
      settle();
      if (i < 3) begin
        checks++;
        if (bus.f_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== NB'(i)) begin
          errors++; $display("FAIL seq_grant %0d got gnt %b en %b we %b addr %0d exp 1 1 0 %0d",
                             i, bus.f_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, i);
        end
      end
      if (i > 0) begin
        checks++;
        if (bus.f_valid !== 1'b1 || bus.f_data !== init_word(i - 1)) begin
          errors++; $display("FAIL seq_data %0d got v %b data %h exp 1 %h",
                             i, bus.f_valid, bus.f_data, init_word(i - 1));
        end
      end
      end_cycle();
    end
    drive(0, 0, 0, 0, 0);
    settle();
    checks++;
    if (bus.f_valid !== 1'b0 || bus.f_data !== init_word(2)) begin
      errors++; $display("FAIL seq_hold got v %b data %h exp 0 %h", bus.f_valid, bus.f_data, init_word(2));
    end
    end_cycle();
  endtask

  task automatic test_fetch_misalign();
    drive(1, 32'h6, 0, 0, 0);
    settle();
    checks++;
    if (bus.f_gnt !== 1'b1 || bus.mem_en !== 1'b0) begin
      errors++; $display("FAIL fmis_grant got gnt %b en %b exp 1 0", bus.f_gnt, bus.mem_en);
    end
    end_cycle();
    drive(0, 0, 0, 0, 0);
    settle();
    checks++;
    if (bus.f_valid !== 1'b1 || bus.f_misalign !== 1'b1 || bus.f_data !== 32'd0) begin
      errors++; $display("FAIL fmis_resp got v %b mis %b data %h exp 1 1 0",
                         bus.f_valid, bus.f_misalign, bus.f_data);
    end
    end_cycle();
  endtask

  task automatic test_write_then_read();
    drive(0, 0, 1, 32'h10, 32'hDEAD_BEEF);
    settle();
    checks++;
    if (bus.l_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
        bus.mem_addr !== NB'(4) || bus.mem_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_req got gnt %b en %b we %b addr %0d wdata %h exp 1 1 1 4 deadbeef",
                         bus.l_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    end_cycle();
    drive(1, 32'hFF00_0010, 0, 0, 0);
    settle();
    checks++;
    if (bus.f_gnt !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== NB'(4) || bus.l_err !== 1'b0) begin
      errors++; $display("FAIL rd_wrap got gnt %b we %b addr %0d lerr %b exp 1 0 4 0",
                         bus.f_gnt, bus.mem_we, bus.mem_addr, bus.l_err);
    end
    end_cycle();
    drive(0, 0, 0, 0, 0);
    settle();
    checks++;
    if (bus.f_valid !== 1'b1 || bus.f_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_data got v %b data %h exp 1 deadbeef", bus.f_valid, bus.f_data);
    end
    end_cycle();
  endtask

  task automatic test_loader_misalign();
    drive(0, 0, 1, 32'h3, 32'h5555_AAAA);
    settle();
    checks++;
    if (bus.l_gnt !== 1'b1 || bus.mem_en !== 1'b0) begin
      errors++; $display("FAIL lmis_grant got gnt %b en %b exp 1 0", bus.l_gnt, bus.mem_en);
    end
    end_cycle();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (bus.l_err !== (i == 0)) begin
        errors++; $display("FAIL lmis_err cyc %0d got %b exp %b", i, bus.l_err, i == 0);
      end
      end_cycle();
    end
  endtask

  task automatic test_starvation();
    drive(0, 0, 0, 0, 0);
    settle();
    end_cycle();
    for (int i = 0; i < 15; i++) begin
      drive(1, 32'h20, 1, 32'(32'h80 + 4 * $urandom_range(0, 15)), $urandom());
      settle();
      checks++;
      if (bus.f_gnt !== (i % 5 == 4) || bus.l_gnt !== (i % 5 != 4)) begin
        errors++; $display("FAIL starve cyc %0d got f %b l %b exp f %b", i, bus.f_gnt, bus.l_gnt, i % 5 == 4);
      end
      checks++;
      if (bus.f_valid !== (i % 5 == 0 && i > 0) || (bus.f_valid && bus.f_data !== e_data)) begin
        errors++; $display("FAIL starve_resp cyc %0d got v %b data %h exp v %b data %h",
                           i, bus.f_valid, bus.f_data, i % 5 == 0 && i > 0, e_data);
      end
      end_cycle();
    end
    drive(0, 0, 0, 0, 0);
    settle();
    end_cycle();
  endtask

  task automatic test_reset_midflight();
    drive(1, 32'h8, 0, 0, 0);
    settle();
    checks++;
    if (bus.f_gnt !== 1'b1) begin
      errors++; $display("FAIL mid_grant got %b exp 1", bus.f_gnt);
    end
    end_cycle();
    rst = 1'b1;
    drive(1, 32'hC, 1, 32'h30, 32'h7);
    settle();
    checks++;
    if ({bus.f_gnt, bus.l_gnt, bus.mem_en} !== 3'b000) begin
      errors++; $display("FAIL mid_rst_ctl got %b exp 000", {bus.f_gnt, bus.l_gnt, bus.mem_en});
    end
    end_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    settle();
    checks++;
    if ({bus.f_valid, bus.f_misalign, bus.l_err} !== 3'b000 || bus.f_data !== 32'd0) begin
      errors++; $display("FAIL mid_after got v/m/e %b data %h exp 000 / 0",
                         {bus.f_valid, bus.f_misalign, bus.l_err}, bus.f_data);
    end
    end_cycle();
  endtask

  task automatic test_random();
    logic pend_f = 0, pend_l = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend_f) begin
        bus.f_req  = ($urandom_range(0, 3) != 0);
        bus.f_addr = rand_addr();
      end
      if (!pend_l) begin
        bus.l_req   = ($urandom_range(0, 1) != 0);
        bus.l_addr  = rand_addr();
        bus.l_wdata = $urandom();
      end
      rst = ($urandom_range(0, 63) == 0);
      settle();
      checks++;
      if ({bus.f_gnt, bus.l_gnt, bus.mem_en, bus.mem_we} !== {e_fg, e_lg, e_en, e_we}) begin
        errors++; $display("FAIL rnd_ctl cyc %0d got %b exp %b", cyc,
                           {bus.f_gnt, bus.l_gnt, bus.mem_en, bus.mem_we}, {e_fg, e_lg, e_en, e_we});
      end
      if (e_en) begin
        checks++;
        if (bus.mem_addr !== e_addr) begin
          errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, bus.mem_addr, e_addr);
        end
      end
      if (e_we) begin
        checks++;
        if (bus.mem_wdata !== bus.l_wdata) begin
          errors++; $display("FAIL rnd_wdata cyc %0d got %h exp %h", cyc, bus.mem_wdata, bus.l_wdata);
        end
      end
      checks++;
      if ({bus.f_valid, bus.f_misalign, bus.l_err} !== {e_valid, e_mis, e_lerr}) begin
        errors++; $display("FAIL rnd_flags cyc %0d got %b exp %b", cyc,
                           {bus.f_valid, bus.f_misalign, bus.l_err}, {e_valid, e_mis, e_lerr});
      end
      checks++;
      if (bus.f_data !== e_data) begin
        errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", cyc, bus.f_data, e_data);
      end
      pend_f = bus.f_req && !e_fg;
      pend_l = bus.l_req && !e_lg;
      end_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fetch_seq();
    test_fetch_misalign();
    test_write_then_read();
    test_loader_misalign();
    test_starvation();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
